posit_weight_streamer: RTL and testbench

Serial weight transmitter for the fp/posit MAC datapath. Accepts parallel posit weights with their paired FP16 activations through a 2-entry buffer, then streams each weight MSB-first, one bit per clock, on the `w`/`valid` serial interface consumed by `fp_posit_mul`. It also issues the one-cycle `set` pulse and the `precision` value that configure the multiplier. It sits between the weight/activation fetch logic and the multiplier.

---
 rtl/posit_weight_streamer.sv | 130 +++++++++++++
 tb/tb_posit_weight_streamer.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/posit_weight_streamer.sv
// Serial posit weight transmitter: buffers {weight, activation} pairs in a 2-entry FIFO
// and streams each weight MSB-first with the set/precision controls for fp_posit_mul.
module posit_weight_streamer #(
  parameter int              ACT_WIDTH = 16,
  parameter int              WGT_WIDTH = 16,
  parameter logic [3:0]      PREC_RST  = 4'd4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WGT_WIDTH-1:0] weight_in,
  input  logic [ACT_WIDTH-1:0] act_in,
  input  logic                 cfg_load,
  input  logic [3:0]           cfg_prec,
  output logic                 cfg_ready,
  output logic [ACT_WIDTH-1:0] act,
  output logic                 w,
  output logic                 valid,
  output logic                 set,
  output logic [3:0]           precision,
  output logic                 word_last
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SET,
    S_STREAM
  } state_t;

  state_t                 state, state_nxt;
  logic [WGT_WIDTH-1:0]   fifo_wgt [2];
  logic [ACT_WIDTH-1:0]   fifo_act [2];
  logic                   rd_ptr, wr_ptr;
  logic [1:0]             count;
  logic [WGT_WIDTH-1:0]   shift_reg;
  logic [3:0]             bit_cnt;
  logic [3:0]             eff_n;
  logic [WGT_WIDTH-1:0]   head_wgt;
  logic [WGT_WIDTH-1:0]   word_mask;
  logic                   push, pop, cfg_accept;

  // Precisions 0 and 1 are too narrow for a posit; they stream as 2-bit words.
  assign eff_n      = (precision < 4'd2) ? 4'd2 : precision;
  assign head_wgt   = fifo_wgt[rd_ptr];
  assign word_mask  = ~({WGT_WIDTH{1'b1}} << eff_n);

  assign in_ready   = (count < 2'd2);
  assign cfg_ready  = (state == S_IDLE) && (count == 2'd0);
  assign push       = in_valid && in_ready;
  assign cfg_accept = cfg_load && cfg_ready;

  always_comb begin
    // NOTE: defaults first so every path assigns every signal and no latch is inferred.
    state_nxt = state;
    pop       = 1'b0;
    case (state)
      S_IDLE: begin
        if (cfg_accept) begin
          state_nxt = S_SET;
        end else if (count != 2'd0) begin
          pop       = 1'b1;
          state_nxt = S_STREAM;
        end
      end
      S_SET: state_nxt = S_IDLE;
      S_STREAM: begin
        if (bit_cnt == 4'd0) begin
          if (count != 2'd0) pop = 1'b1;
          else               state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // NOTE: the FIFO storage has no reset; entries are only read behind count, which is reset.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_wgt[wr_ptr] <= weight_in;
      fifo_act[wr_ptr] <= act_in;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= S_IDLE;
      rd_ptr    <= 1'b0;
      wr_ptr    <= 1'b0;
      count     <= 2'd0;
      precision <= PREC_RST;
      shift_reg <= '0;
      bit_cnt   <= 4'd0;
      act       <= '0;
      w         <= 1'b0;
      valid     <= 1'b0;
      set       <= 1'b0;
      word_last <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state <= state_nxt;
      if (push) wr_ptr <= ~wr_ptr;
      if (pop)  rd_ptr <= ~rd_ptr;
      if (push && !pop)      count <= count + 2'd1;
      else if (!push && pop) count <= count - 2'd1;

      if (cfg_accept) precision <= cfg_prec;
      set <= cfg_accept;

      if (pop) begin
        shift_reg <= head_wgt & word_mask;
        bit_cnt   <= eff_n - 4'd1;
        w         <= head_wgt[eff_n - 4'd1];
        act       <= fifo_act[rd_ptr];
        valid     <= 1'b1;
        word_last <= 1'b0;
      end else if (state == S_STREAM && bit_cnt != 4'd0) begin
        bit_cnt   <= bit_cnt - 4'd1;
        w         <= shift_reg[bit_cnt - 4'd1];
        valid     <= 1'b1;
        word_last <= (bit_cnt == 4'd1);
      end else begin
        w         <= 1'b0;
        valid     <= 1'b0;
        word_last <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_posit_weight_streamer.sv
// Directed bench for posit_weight_streamer: table-driven single words plus hand-written
// sequences for back-to-back streaming, config during a stream and reset mid-word.
module tb_posit_weight_streamer;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] weight_in;
  logic [15:0] act_in;
  logic        cfg_load;
  logic [3:0]  cfg_prec;
  logic        cfg_ready;
  logic [15:0] act;
  logic        w;
  logic        valid;
  logic        set;
  logic [3:0]  precision;
  logic        word_last;

  int checks   = 0;
  int failures = 0;
  logic [3:0] cur_prec;

  always #5 clk = ~clk;

  posit_weight_streamer #(
    .ACT_WIDTH(16),
    .WGT_WIDTH(16),
    .PREC_RST (4'd4)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .weight_in(weight_in),
    .act_in   (act_in),
    .cfg_load (cfg_load),
    .cfg_prec (cfg_prec),
    .cfg_ready(cfg_ready),
    .act      (act),
    .w        (w),
    .valid    (valid),
    .set      (set),
    .precision(precision),
    .word_last(word_last)
  );

  typedef struct {
    logic [3:0]  prec;
    logic [15:0] weight;
    logic [15:0] act_val;
    logic [15:0] exp_bits;
    int          n;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_cfg(input logic [3:0] prec);
    int guard = 0;
    while (!cfg_ready && guard < 50) begin
      step();
      guard++;
    end
    check("cfg_ready_wait", {31'd0, cfg_ready}, 32'd1);
    cfg_load = 1'b1;
    cfg_prec = prec;
    step();
    cfg_load = 1'b0;
    check($sformatf("cfg%0d_set_high", prec), {31'd0, set}, 32'd1);
    check($sformatf("cfg%0d_precision", prec), {28'd0, precision}, {28'd0, prec});
    check($sformatf("cfg%0d_valid_low", prec), {31'd0, valid}, 32'd0);
    step();
    check($sformatf("cfg%0d_set_one_cycle", prec), {31'd0, set}, 32'd0);
    cur_prec = prec;
  endtask

  task automatic run_word(input int idx, input vec_t v);
    if (v.prec != cur_prec) do_cfg(v.prec);
    in_valid  = 1'b1;
    weight_in = v.weight;
    act_in    = v.act_val;
    step();
    in_valid = 1'b0;
    check($sformatf("v%0d_no_early_valid", idx), {31'd0, valid}, 32'd0);
    step();
    for (int i = v.n - 1; i >= 0; i--) begin
      check($sformatf("v%0d_valid_b%0d", idx, i), {31'd0, valid}, 32'd1);
      check($sformatf("v%0d_w_b%0d", idx, i), {31'd0, w}, {31'd0, v.exp_bits[i]});
      check($sformatf("v%0d_last_b%0d", idx, i), {31'd0, word_last}, (i == 0) ? 32'd1 : 32'd0);
      check($sformatf("v%0d_act_b%0d", idx, i), {16'd0, act}, {16'd0, v.act_val});
      step();
    end
    check($sformatf("v%0d_valid_after", idx), {31'd0, valid}, 32'd0);
  endtask

  initial begin
    logic [11:0] exp12;
    logic [15:0] bb_w [3];
    logic [15:0] bb_a [3];
    int nv, first_c, last_c, guard, nvalid;

    vecs[0] = '{4'd8,  16'h00A5, 16'hA501, 16'h00A5, 8};
    vecs[1] = '{4'd8,  16'hFF3C, 16'h0BEE, 16'h003C, 8};
    vecs[2] = '{4'd4,  16'h000B, 16'h1234, 16'h000B, 4};
    vecs[3] = '{4'd4,  16'hFFF4, 16'h4321, 16'h0004, 4};
    vecs[4] = '{4'd0,  16'h0003, 16'h0F0F, 16'h0003, 2};
    vecs[5] = '{4'd1,  16'h0002, 16'hF0F0, 16'h0002, 2};
    vecs[6] = '{4'd15, 16'h5555, 16'h7777, 16'h5555, 15};

    rst       = 1'b0;
    in_valid  = 1'b0;
    weight_in = '0;
    act_in    = '0;
    cfg_load  = 1'b0;
    cfg_prec  = '0;
    cur_prec  = 4'd4;

    // Reset state
    step();
    step();
    rst = 1'b1;
    step();
    check("rst_valid",     {31'd0, valid},     32'd0);
    check("rst_w",         {31'd0, w},         32'd0);
    check("rst_set",       {31'd0, set},       32'd0);
    check("rst_last",      {31'd0, word_last}, 32'd0);
    check("rst_act",       {16'd0, act},       32'd0);
    check("rst_precision", {28'd0, precision}, 32'd4);
    check("rst_in_ready",  {31'd0, in_ready},  32'd1);
    check("rst_cfg_ready", {31'd0, cfg_ready}, 32'd1);

    // Explicit configure to 4 bits
    do_cfg(4'd4);

    // Back-to-back words with continuous in_valid
    exp12   = 12'b1011_0100_1111;
    bb_w[0] = 16'h000B; bb_w[1] = 16'h0004; bb_w[2] = 16'h000F;
    bb_a[0] = 16'h1234; bb_a[1] = 16'h5678; bb_a[2] = 16'h9ABC;
    nv = 0; first_c = -1; last_c = -1;
    in_valid  = 1'b1;
    weight_in = bb_w[0];
    act_in    = bb_a[0];
    for (int c = 0; c < 20; c++) begin
      step();
      if (valid) begin
        if (first_c < 0) first_c = c;
        last_c = c;
        if (nv < 12) begin
          check($sformatf("bb_w_%0d", nv), {31'd0, w}, {31'd0, exp12[11 - nv]});
          check($sformatf("bb_act_%0d", nv), {16'd0, act}, {16'd0, bb_a[nv / 4]});
          check($sformatf("bb_last_%0d", nv), {31'd0, word_last}, (nv % 4 == 3) ? 32'd1 : 32'd0);
        end
        nv++;
      end
      if (c == 0) begin
        weight_in = bb_w[1];
        act_in    = bb_a[1];
      end else if (c == 1) begin
        weight_in = bb_w[2];
        act_in    = bb_a[2];
      end else if (c == 2) begin
        check("bb_in_ready_full", {31'd0, in_ready}, 32'd0);
        in_valid = 1'b0;
      end
    end
    check("bb_valid_count", nv, 32'd12);
    check("bb_contiguous", last_c - first_c + 1, 32'd12);
    check("bb_in_ready_after", {31'd0, in_ready}, 32'd1);

    // cfg_load during a stream is ignored until the block is idle
    in_valid  = 1'b1;
    weight_in = 16'h000F;
    act_in    = 16'h2222;
    step();
    in_valid = 1'b0;
    step();
    check("cs_streaming", {31'd0, valid}, 32'd1);
    check("cs_cfg_ready_low", {31'd0, cfg_ready}, 32'd0);
    cfg_load = 1'b1;
    cfg_prec = 4'd8;
    guard  = 0;
    nvalid = 0;
    while (guard < 20) begin
      step();
      guard++;
      if (set) break;
      check($sformatf("cs_prec_hold_%0d", guard), {28'd0, precision}, 32'd4);
      if (valid) nvalid++;
    end
    cfg_load = 1'b0;
    check("cs_set_seen", {31'd0, set}, 32'd1);
    check("cs_prec_new", {28'd0, precision}, 32'd8);
    check("cs_set_valid_low", {31'd0, valid}, 32'd0);
    check("cs_word_finished", nvalid, 32'd3);
    step();
    check("cs_set_one_cycle", {31'd0, set}, 32'd0);
    cur_prec = 4'd8;

    // Table-driven single words
    for (int i = 0; i < 7; i++) run_word(i, vecs[i]);

    // Reset mid-word
    in_valid  = 1'b1;
    weight_in = 16'h5555;
    act_in    = 16'h3333;
    step();
    weight_in = 16'h7FFF;
    step();
    in_valid = 1'b0;
    step();
    check("mr_streaming", {31'd0, valid}, 32'd1);
    rst = 1'b0;
    #1;
    check("mr_valid_async", {31'd0, valid},     32'd0);
    check("mr_w_async",     {31'd0, w},         32'd0);
    check("mr_act_async",   {16'd0, act},       32'd0);
    check("mr_prec_async",  {28'd0, precision}, 32'd4);
    check("mr_in_ready",    {31'd0, in_ready},  32'd1);
    check("mr_cfg_ready",   {31'd0, cfg_ready}, 32'd1);
    step();
    rst = 1'b1;
    nvalid = 0;
    for (int c = 0; c < 25; c++) begin
      step();
      if (valid) nvalid++;
    end
    check("mr_no_bits_after", nvalid, 32'd0);
    check("mr_fifo_empty", {31'd0, cfg_ready}, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
